// File: rtl/slow_clock_monitor_pkg.sv
// Shared definitions for the slow clock monitor and the clock divider that feeds it.
//
// Contents:
//   state_e              - monitor FSM state encoding (2 bits)
//   FastClkHz/SlowClkHz  - default system and divided clock rates
//   Default*             - parameter defaults derived from those rates
package slow_clock_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2,
        StLost    = 2'd3
    } state_e;

    localparam int unsigned FastClkHz = 25_000_000;
    localparam int unsigned SlowClkHz = 200;

    // 125000 fast cycles per slow period; 1% tolerance either side.
    localparam int unsigned DefaultNominalPeriod = FastClkHz / SlowClkHz;
    localparam int unsigned DefaultTolerance     = DefaultNominalPeriod / 100;
    localparam int unsigned DefaultLockCount     = 4;
    localparam int unsigned DefaultCntW          = 18;
    localparam int unsigned DefaultSyncStages    = 2;

endpackage

// File: rtl/slow_clock_monitor_edge_sync.sv
// Synchronizes the asynchronous slow clock into the fast domain and flags its rising edges.
//
// Ports:
//   clock_i   - fast system clock
//   reset_i   - synchronous active-high reset; clears all flops
//   async_i   - asynchronous level input (slow clock square wave)
//   rise_o    - high for one cycle when the synchronized level goes 0 -> 1 (combinational)
module slow_clock_monitor_edge_sync
    import slow_clock_monitor_pkg::*;
#(
    // Must be at least 2.
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/slow_clock_monitor.sv
// Monitors the divided slow clock from the fast clock domain.
//
// Produces a one-cycle tick per slow rising edge so downstream logic can use it as an
// enable, measures the slow period in fast cycles, declares lock after LOCK_COUNT
// consecutive in-tolerance periods and flags loss when no edge arrives in time.
//
// Ports:
//   clock_i         - fast system clock (25 MHz)
//   reset_i         - synchronous active-high reset
//   slow_clock_i    - divided square wave, treated as asynchronous data
//   tick_o          - one-cycle pulse per detected slow rising edge
//   period_o        - last measured period in fast cycles
//   period_valid_o  - a full period has been measured since reset or loss
//   locked_o        - LOCK_COUNT consecutive in-tolerance periods seen
//   lost_o          - no rising edge within NOMINAL_PERIOD+TOLERANCE cycles
module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int unsigned NOMINAL_PERIOD = DefaultNominalPeriod,
    parameter int unsigned TOLERANCE      = DefaultTolerance,
    parameter int unsigned LOCK_COUNT     = DefaultLockCount,
    // Must satisfy 2**CNT_W-1 > NOMINAL_PERIOD+TOLERANCE.
    parameter int unsigned CNT_W          = DefaultCntW,
    parameter int unsigned SYNC_STAGES    = DefaultSyncStages
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             slow_clock_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             lost_o
);

    localparam int unsigned CntW1   = CNT_W + 1;
    localparam int unsigned ConsecW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

    // Window bounds and measured length share one extra bit so the compares never wrap.
    localparam logic [CNT_W:0] TolHi = CntW1'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [CNT_W:0] TolLo =
        (NOMINAL_PERIOD > TOLERANCE) ? CntW1'(NOMINAL_PERIOD - TOLERANCE) : '0;
    localparam logic [ConsecW-1:0] LockTarget = ConsecW'(LOCK_COUNT);

    logic rise;

    slow_clock_monitor_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .async_i (slow_clock_i),
        .rise_o  (rise)
    );

    // ---------------------------------------------------------------------------------
    // Period counter: restarts on every rise, saturates instead of wrapping.
    // ---------------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts cycles since the previous rise cycle, so the period ending now is cnt+1.
    logic [CNT_W:0] meas_len;
    logic           in_tol;
    logic           timeout;

    assign meas_len = {1'b0, cnt_q} + CntW1'(1);
    assign in_tol   = (meas_len >= TolLo) && (meas_len <= TolHi);
    assign timeout  = ({1'b0, cnt_q} >= TolHi);

    // ---------------------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------------------
    state_e             state_q;
    logic [ConsecW-1:0] consec_q;
    logic [ConsecW-1:0] consec_inc;
    logic               tick_q;
    logic [CNT_W-1:0]   period_q;
    logic               period_valid_q;
    logic               locked_q;
    logic               lost_q;

    assign consec_inc = consec_q + ConsecW'(1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            consec_q       <= '0;
            tick_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            tick_q <= rise;
            unique case (state_q)
                // The first edge only starts a measurement; there is nothing to time yet.
                StIdle: begin
                    if (rise) begin
                        state_q <= StMeasure;
                    end
                end

                StMeasure: begin
                    // A rise on the threshold cycle is checked first so it is recorded.
                    if (rise) begin
                        period_q       <= meas_len[CNT_W-1:0];
                        period_valid_q <= 1'b1;
                        if (in_tol) begin
                            consec_q <= consec_inc;
                            if (consec_inc == LockTarget) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            consec_q <= '0;
                        end
                    end else if (timeout) begin
                        state_q        <= StLost;
                        lost_q         <= 1'b1;
                        locked_q       <= 1'b0;
                        period_valid_q <= 1'b0;
                        consec_q       <= '0;
                    end
                end

                StLocked: begin
                    if (rise) begin
                        period_q       <= meas_len[CNT_W-1:0];
                        period_valid_q <= 1'b1;
                        if (!in_tol) begin
                            state_q  <= StMeasure;
                            locked_q <= 1'b0;
                            consec_q <= '0;
                        end
                    end else if (timeout) begin
                        state_q        <= StLost;
                        lost_q         <= 1'b1;
                        locked_q       <= 1'b0;
                        period_valid_q <= 1'b0;
                        consec_q       <= '0;
                    end
                end

                // The count accumulated while lost is not a real period; just restart.
                StLost: begin
                    if (rise) begin
                        state_q <= StMeasure;
                        lost_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tick_o         = tick_q;
    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;
    assign locked_o       = locked_q;
    assign lost_o         = lost_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Self-checking bench for slow_clock_monitor with a small period, using a reference
// model that predicts the outputs seen with each tick.
module tb_slow_clock_monitor;

    localparam int unsigned Nom        = 20;
    localparam int unsigned Tol        = 2;
    localparam int unsigned LockCnt    = 3;
    localparam int unsigned CntW       = 8;
    localparam int unsigned SyncStages = 2;

    localparam int MIdle    = 0;
    localparam int MMeasure = 1;
    localparam int MLocked  = 2;

    logic            clk;
    logic            rst;
    logic            slow;
    logic            tick;
    logic [CntW-1:0] period;
    logic            pv;
    logic            locked;
    logic            lost;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_rise_cyc = 0;

    // Reference model state
    int              m_state  = MIdle;
    int              m_consec = 0;
    logic [CntW-1:0] m_period = '0;
    logic            m_pv     = 1'b0;
    logic            m_locked = 1'b0;

    // Expected {period, period_valid, locked, lost} for each driven rise
    logic [CntW+2:0] exp_q[$];
    logic [CntW+2:0] mon_exp;

    slow_clock_monitor #(
        .NOMINAL_PERIOD (Nom),
        .TOLERANCE      (Tol),
        .LOCK_COUNT     (LockCnt),
        .CNT_W          (CntW),
        .SYNC_STAGES    (SyncStages)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .slow_clock_i   (slow),
        .tick_o         (tick),
        .period_o       (period),
        .period_valid_o (pv),
        .locked_o       (locked),
        .lost_o         (lost)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model update for one rise, given the fast cycles since the previous rise.
    task automatic model_rise(input int gap);
        if (m_state == MIdle) begin
            m_state = MMeasure;
        end else if (gap >= int'(Nom + Tol + 2)) begin
            // Timeout fired before this rise; the rise then only leaves the lost state.
            m_pv     = 1'b0;
            m_locked = 1'b0;
            m_consec = 0;
            m_state  = MMeasure;
        end else begin
            m_period = CntW'(gap);
            m_pv     = 1'b1;
            if (gap >= int'(Nom - Tol) && gap <= int'(Nom + Tol)) begin
                if (m_state == MMeasure) begin
                    m_consec++;
                    if (m_consec == int'(LockCnt)) begin
                        m_state  = MLocked;
                        m_locked = 1'b1;
                    end
                end
            end else begin
                m_consec = 0;
                m_locked = 1'b0;
                m_state  = MMeasure;
            end
        end
        exp_q.push_back({m_period, m_pv, m_locked, 1'b0});
    endtask

    task automatic model_reset();
        m_state  = MIdle;
        m_consec = 0;
        m_period = '0;
        m_pv     = 1'b0;
        m_locked = 1'b0;
        exp_q.delete();
    endtask

    // Called at a negedge: raise slow_clock and predict the resulting tick.
    task automatic drive_rise();
        model_rise(cyc - last_rise_cyc);
        last_rise_cyc = cyc;
        slow = 1'b1;
    endtask

    // One slow period of g fast cycles starting with a rising edge.
    task automatic slow_period(input int g);
        drive_rise();
        hold(g / 2);
        slow = 1'b0;
        hold(g - g / 2);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tick"}, tick, 0);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_valid"}, pv, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_lost"}, lost, 0);
    endtask

    // Scoreboard: every tick must match the oldest prediction.
    always @(negedge clk) begin
        if (rst === 1'b0 && tick === 1'b1) begin
            check_eq("tick_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("tick_period", period, mon_exp[CntW+2:3]);
                check_eq("tick_valid", pv, mon_exp[2]);
                check_eq("tick_locked", locked, mon_exp[1]);
                check_eq("tick_lost", lost, mon_exp[0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    int tol_seq[12] = '{18, 22, 23, 20, 20, 20, 17, 20, 20, 20, 23, 20};

    initial begin
        rst  = 1'b1;
        slow = 1'b0;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b0;
        hold(3);

        // First edge: tick appears on the third negedge after driving high
        drive_rise();
        hold(2);
        check_eq("first_tick_early", tick, 0);
        hold(1);
        check_eq("first_tick", tick, 1);
        check_eq("first_tick_valid", pv, 0);
        hold(7);
        slow = 1'b0;
        hold(10);

        // Lock acquisition: locked coincides with tick 4
        for (int i = 0; i < 3; i++) slow_period(20);
        check_eq("locked_after_tick4", locked, 1);

        // Tolerance edges, unlock/relock, and a rise exactly at the timeout threshold
        foreach (tol_seq[i]) slow_period(tol_seq[i]);
        check_eq("race_no_lost", lost, 0);

        // Relock, then stop the slow clock
        for (int i = 0; i < 3; i++) slow_period(20);
        check_eq("relocked", locked, 1);
        drive_rise();
        hold(10);
        slow = 1'b0;
        hold(15);
        check_eq("loss_not_yet", lost, 0);
        check_eq("loss_still_locked", locked, 1);
        hold(1);
        check_eq("loss_lost", lost, 1);
        check_eq("loss_locked", locked, 0);
        check_eq("loss_valid", pv, 0);
        check_eq("loss_period_hold", period, 20);
        hold(14);
        // Recovery edge records nothing; following edges measure again
        for (int i = 0; i < 4; i++) slow_period(20);
        check_eq("recovered_locked", locked, 1);

        // Reset while locked with cnt at 10
        drive_rise();
        hold(10);
        slow = 1'b0;
        hold(3);
        check_eq("pre_reset_locked", locked, 1);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        model_reset();
        check_all_zero("mid_reset");
        hold(7);

        // Fresh lock needs 4 ticks
        for (int i = 0; i < 3; i++) slow_period(20);
        check_eq("fresh_not_locked", locked, 0);
        slow_period(20);
        check_eq("fresh_locked", locked, 1);

        hold(5);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
